// File: rtl/dp_neuron_collector.sv
// Collects CHUNKS partial dot products per neuron, adds bias, applies ReLU and
// saturation, emits one activation per neuron and the argmax class after NEURONS.
module dp_neuron_collector #(
  parameter int VAL_SIZE = 26,
  parameter int CHUNKS   = 4,
  parameter int NEURONS  = 10,
  parameter int LATENCY  = 24,
  parameter int IDX_SIZE = 4,
  parameter int ACC_SIZE = VAL_SIZE + 4
) (
  input  logic                       clk,
  input  logic                       GlobalReset,
  input  logic                       start,
  input  logic signed [VAL_SIZE-1:0] dp_value,
  input  logic signed [VAL_SIZE-1:0] bias,
  output logic                       busy,
  output logic                       neuron_valid,
  output logic        [VAL_SIZE-1:0] neuron_value,
  output logic        [IDX_SIZE-1:0] neuron_index,
  output logic                       class_valid,
  output logic        [IDX_SIZE-1:0] class_index,
  output logic        [VAL_SIZE-1:0] class_value,
  output logic                       err
);

  localparam int WAIT_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam int CHUNK_W = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;

  localparam logic [WAIT_W-1:0]          WAIT_LOAD   = WAIT_W'(LATENCY - 1);
  localparam logic [CHUNK_W-1:0]         LAST_CHUNK  = CHUNK_W'(CHUNKS - 1);
  localparam logic [IDX_SIZE-1:0]        LAST_NEURON = IDX_SIZE'(NEURONS - 1);
  localparam logic signed [ACC_SIZE-1:0] SAT_MAX =
    {{(ACC_SIZE - VAL_SIZE + 1){1'b0}}, {(VAL_SIZE - 1){1'b1}}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_FINAL
  } state_t;

  state_t                       r_state;
  state_t                       w_state_next;
  logic        [WAIT_W-1:0]     r_wait_cnt;
  logic        [CHUNK_W-1:0]    r_chunk_cnt;
  logic        [IDX_SIZE-1:0]   r_neuron_cnt;
  logic signed [ACC_SIZE-1:0]   r_acc;
  logic        [VAL_SIZE-1:0]   r_best_val;
  logic        [IDX_SIZE-1:0]   r_best_idx;
  logic                         r_neuron_valid;
  logic        [VAL_SIZE-1:0]   r_neuron_value;
  logic        [IDX_SIZE-1:0]   r_neuron_index;
  logic                         r_class_valid;
  logic        [IDX_SIZE-1:0]   r_class_index;
  logic        [VAL_SIZE-1:0]   r_class_value;
  logic                         r_err;

  logic                         w_capture;
  logic                         w_last_chunk;
  logic                         w_last_neuron;
  logic signed [ACC_SIZE-1:0]   w_sum;
  logic        [VAL_SIZE-1:0]   w_result;
  logic                         w_take_best;
  logic        [VAL_SIZE-1:0]   w_best_val;
  logic        [IDX_SIZE-1:0]   w_best_idx;

  assign w_capture     = (r_state == S_WAIT) && (r_wait_cnt == '0);
  assign w_last_chunk  = (r_chunk_cnt == LAST_CHUNK);
  assign w_last_neuron = (r_neuron_cnt == LAST_NEURON);

  // Activation of the neuron finishing in FINAL, plus the argmax including it.
  // NOTE: every signal driven here gets a value on every path, so no latch is inferred.
  always_comb begin
    w_sum = r_acc + ACC_SIZE'(bias);
    if (w_sum[ACC_SIZE-1])
      w_result = '0;
    else if (w_sum > SAT_MAX)
      w_result = SAT_MAX[VAL_SIZE-1:0];
    else
      w_result = w_sum[VAL_SIZE-1:0];
    w_take_best = (r_neuron_cnt == '0) || (w_result > r_best_val);
    w_best_val  = w_take_best ? w_result : r_best_val;
    w_best_idx  = w_take_best ? r_neuron_cnt : r_best_idx;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_next = S_WAIT;
      S_WAIT:  if (w_capture) w_state_next = w_last_chunk ? S_FINAL : S_IDLE;
      S_FINAL: w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge GlobalReset) begin
    if (GlobalReset) begin
      r_state        <= S_IDLE;
      r_wait_cnt     <= '0;
      r_chunk_cnt    <= '0;
      r_neuron_cnt   <= '0;
      r_acc          <= '0;
      r_best_val     <= '0;
      r_best_idx     <= '0;
      r_neuron_valid <= 1'b0;
      r_neuron_value <= '0;
      r_neuron_index <= '0;
      r_class_valid  <= 1'b0;
      r_class_index  <= '0;
      r_class_value  <= '0;
      r_err          <= 1'b0;
    end else begin
      r_state        <= w_state_next;
      r_neuron_valid <= 1'b0;
      r_class_valid  <= 1'b0;
      if (start && (r_state != S_IDLE))
        r_err <= 1'b1;

      case (r_state)
        S_IDLE: begin
          if (start)
            r_wait_cnt <= WAIT_LOAD;
        end
        S_WAIT: begin
          if (r_wait_cnt != '0) begin
            r_wait_cnt <= r_wait_cnt - 1'b1;
          end else begin
            r_acc       <= r_acc + ACC_SIZE'(dp_value);
            r_chunk_cnt <= w_last_chunk ? '0 : r_chunk_cnt + 1'b1;
          end
        end
        S_FINAL: begin
          r_neuron_valid <= 1'b1;
          r_neuron_value <= w_result;
          r_neuron_index <= r_neuron_cnt;
          r_best_val     <= w_best_val;
          r_best_idx     <= w_best_idx;
          r_acc          <= '0;
          if (w_last_neuron) begin
            r_class_valid <= 1'b1;
            r_class_index <= w_best_idx;
            r_class_value <= w_best_val;
            r_neuron_cnt  <= '0;
          end else begin
            r_neuron_cnt <= r_neuron_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy         = (r_state != S_IDLE);
  assign neuron_valid = r_neuron_valid;
  assign neuron_value = r_neuron_value;
  assign neuron_index = r_neuron_index;
  assign class_valid  = r_class_valid;
  assign class_index  = r_class_index;
  assign class_value  = r_class_value;
  assign err          = r_err;

endmodule

// File: tb/tb_dp_neuron_collector.sv
// Randomized self-checking bench for dp_neuron_collector against a
// neuron-level arithmetic model (sum chunks + bias, clamp, first-max argmax).
module tb_dp_neuron_collector;

  localparam int VAL_SIZE = 26;
  localparam int CHUNKS   = 2;
  localparam int NEURONS  = 3;
  localparam int LATENCY  = 4;
  localparam int IDX_SIZE = 4;
  localparam longint ACT_MAX = (64'sd1 <<< (VAL_SIZE - 1)) - 1;

  logic                       clk = 1'b0;
  logic                       GlobalReset;
  logic                       start;
  logic signed [VAL_SIZE-1:0] dp_value;
  logic signed [VAL_SIZE-1:0] bias;
  logic                       busy;
  logic                       neuron_valid;
  logic        [VAL_SIZE-1:0] neuron_value;
  logic        [IDX_SIZE-1:0] neuron_index;
  logic                       class_valid;
  logic        [IDX_SIZE-1:0] class_index;
  logic        [VAL_SIZE-1:0] class_value;
  logic                       err;

  dp_neuron_collector #(
    .VAL_SIZE(VAL_SIZE),
    .CHUNKS  (CHUNKS),
    .NEURONS (NEURONS),
    .LATENCY (LATENCY),
    .IDX_SIZE(IDX_SIZE)
  ) dut (
    .clk         (clk),
    .GlobalReset (GlobalReset),
    .start       (start),
    .dp_value    (dp_value),
    .bias        (bias),
    .busy        (busy),
    .neuron_valid(neuron_valid),
    .neuron_value(neuron_value),
    .neuron_index(neuron_index),
    .class_valid (class_valid),
    .class_index (class_index),
    .class_value (class_value),
    .err         (err)
  );

  always #5 clk = ~clk;

  int     total = 0;
  int     bad   = 0;
  int     nidx  = 0;
  longint acts[NEURONS];
  longint held_cls_idx = 0;
  longint held_cls_val = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  function automatic longint relu_sat(input longint s);
    if (s < 0) return 0;
    if (s > ACT_MAX) return ACT_MAX;
    return s;
  endfunction

  function automatic int rand_val();
    if ($urandom_range(0, 3) == 0) return int'($urandom) >>> 6;
    return int'($urandom_range(0, 4000)) - 2000;
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"},   busy, 0);
    check({tag, "_nvalid"}, neuron_valid, 0);
    check({tag, "_nvalue"}, neuron_value, 0);
    check({tag, "_nindex"}, neuron_index, 0);
    check({tag, "_cvalid"}, class_valid, 0);
    check({tag, "_cindex"}, class_index, 0);
    check({tag, "_cvalue"}, class_value, 0);
    check({tag, "_err"},    err, 0);
  endtask

  // Called at the negedge before the start edge E; returns at the negedge
  // after edge E+LATENCY, the capture edge being E+LATENCY.
  task automatic run_chunk(input int val, input int noise, input bit collide);
    start    = 1'b1;
    dp_value = VAL_SIZE'(noise);
    @(negedge clk);
    start = 1'b0;
    check("chunk_busy", busy, 1);
    check("chunk_nvalid_low", neuron_valid, 0);
    check("chunk_cvalid_low", class_valid, 0);
    for (int k = 2; k <= LATENCY; k++) begin
      @(negedge clk);
      start = collide && (k == 2);
      if (k == LATENCY) dp_value = VAL_SIZE'(val);
    end
    @(negedge clk);
    dp_value = VAL_SIZE'(noise);
  endtask

  task automatic run_neuron(input int c0, input int c1, input int b,
                            input int noise, input bit collide);
    longint exp_act;
    int     best;
    bias = VAL_SIZE'(b);
    run_chunk(c0, noise, collide);
    run_chunk(c1, noise, 1'b0);
    check("final_busy", busy, 1);
    check("final_nvalid_low", neuron_valid, 0);
    exp_act    = relu_sat(longint'(c0) + longint'(c1) + longint'(b));
    acts[nidx] = exp_act;
    @(negedge clk);
    check("nvalid", neuron_valid, 1);
    check("nvalue", neuron_value, exp_act);
    check("nindex", neuron_index, nidx);
    check("idle_after", busy, 0);
    if (nidx == NEURONS - 1) begin
      best = 0;
      for (int i = 1; i < NEURONS; i++)
        if (acts[i] > acts[best]) best = i;
      held_cls_idx = best;
      held_cls_val = acts[best];
      check("cvalid", class_valid, 1);
      check("cindex", class_index, held_cls_idx);
      check("cvalue", class_value, held_cls_val);
      nidx = 0;
    end else begin
      check("cvalid_low", class_valid, 0);
      check("cindex_hold", class_index, held_cls_idx);
      check("cvalue_hold", class_value, held_cls_val);
      nidx++;
    end
  endtask

  initial begin
    GlobalReset = 1'b1;
    start       = 1'b0;
    dp_value    = '0;
    bias        = '0;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    GlobalReset = 1'b0;
    @(negedge clk);

    // Basic, ReLU and saturation neurons; class is the saturated one.
    run_neuron(100, 50, -20, rand_val(), 1'b0);
    run_neuron(-300, 100, 0, rand_val(), 1'b0);
    run_neuron(32'h1FFFFFF, 32'h1FFFFFF, 1, rand_val(), 1'b0);
    check("err_clean", err, 0);

    // Tie at 90: the lower index wins; first neuron index wraps to 0.
    run_neuron(30, 10, 0, rand_val(), 1'b0);
    run_neuron(50, 50, -10, rand_val(), 1'b0);
    run_neuron(45, 45, 0, rand_val(), 1'b0);

    // Collision during WAIT plus constant background on dp_value.
    run_neuron(1000, 1000, 0, 7, 1'b1);
    check("err_set", err, 1);

    // Abort neuron 1 while waiting, then confirm asynchronous clear.
    start = 1'b1;
    bias  = VAL_SIZE'(rand_val());
    @(negedge clk);
    start = 1'b0;
    check("err_sticky", err, 1);
    @(negedge clk);
    #1 GlobalReset = 1'b1;
    #1 check_all_zero("midreset");
    @(negedge clk);
    GlobalReset  = 1'b0;
    nidx         = 0;
    held_cls_idx = 0;
    held_cls_val = 0;

    for (int r = 0; r < 4; r++)
      for (int n = 0; n < NEURONS; n++)
        run_neuron(rand_val(), rand_val(), rand_val(), rand_val(), 1'b0);
    check("err_final", err, 0);

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dp_neuron_collector.md
Name: dp_neuron_collector

Overview:
- Downstream of the dot-product stage.
- Samples the dot-product `value` a fixed number of cycles after each chunk launch. Accumulates CHUNKS partial dot products per neuron, adds a bias, applies ReLU and saturation, and emits one neuron activation per neuron.
- Tracks the running argmax over NEURONS neurons and reports the winning class after the last neuron.

Parameters:
- VAL_SIZE, 26, width of dp_value, bias and neuron_value; signed two's complement.
- CHUNKS, 4, partial dot products summed per neuron (>=1).
- NEURONS, 10, neurons per classification (>=1).
- LATENCY, 24, cycles from the edge sampling start=1 to the edge at which dp_value is valid (>=1).
- IDX_SIZE, 4, width of neuron/class index (2^IDX_SIZE >= NEURONS).
- ACC_SIZE, VAL_SIZE+4, internal accumulator width.

Ports:
- clk, input, 1, clock; all logic on the rising edge.
- GlobalReset, input, 1, asynchronous active-high reset.
- start, input, 1, one-cycle pulse: upstream has launched a new chunk into the dot-product stage.
- dp_value, input, VAL_SIZE, dot-product result, signed.
- bias, input, VAL_SIZE, signed bias of the current neuron; sampled in FINAL.
- busy, output, 1, high in every state except IDLE.
- neuron_valid, output, 1, one-cycle pulse; neuron_value and neuron_index are valid.
- neuron_value, output, VAL_SIZE, ReLU/saturated activation.
- neuron_index, output, IDX_SIZE, index of the emitted neuron.
- class_valid, output, 1, one-cycle pulse after the last neuron.
- class_index, output, IDX_SIZE, argmax neuron index.
- class_value, output, VAL_SIZE, activation of the winning neuron.
- err, output, 1, sticky; start seen while busy.

Behaviour:
- Reset: every output is 0, acc=0, chunk_cnt=0, neuron_cnt=0, best_val=0, best_idx=0, wait_cnt=0, state=IDLE.
  - Reset asserted mid-operation aborts immediately. Partial sums and argmax are discarded.
- States: IDLE, WAIT, FINAL.
- IDLE: on start=1, load wait_cnt=LATENCY-1 and go to WAIT.
- WAIT:
  - If wait_cnt!=0, decrement wait_cnt.
  - If wait_cnt==0 on this edge, capture: acc <= acc + sign-extended dp_value.
    - Capture edge = start edge + LATENCY.
  - After capture: if chunk_cnt==CHUNKS-1, go to FINAL with chunk_cnt=0. Otherwise chunk_cnt++ and go to IDLE.
- FINAL, a single cycle:
  - r = acc + sign-extended bias, computed at ACC_SIZE.
  - ReLU: r<0 gives 0.
  - Saturate: r > 2^(VAL_SIZE-1)-1 gives 2^(VAL_SIZE-1)-1.
  - On the FINAL edge register neuron_value=result, neuron_index=neuron_cnt, neuron_valid=1.
  - Argmax: if neuron_cnt==0 or result > best_val (strict), set best_val=result and best_idx=neuron_cnt. Ties keep the lower index.
  - If neuron_cnt==NEURONS-1:
    - On the same edge assert class_valid=1.
    - class_index/class_value take the updated best, including the current neuron.
    - Set neuron_cnt=0.
  - Otherwise neuron_cnt++.
  - acc=0; next state IDLE.
- Latency: neuron_valid is high in the cycle after edge E+LATENCY+1, where E is the edge sampling the last chunk's start.
- Pulses: neuron_valid and class_valid are high for exactly one cycle, then 0. neuron_value, neuron_index, class_index and class_value hold until overwritten.
- start while busy (WAIT or FINAL): ignored, no state change, err set to 1. err stays set until reset.
- start in IDLE in the same cycle FINAL returns to IDLE: not possible, because FINAL precedes IDLE.
  - A start on the cycle after FINAL is accepted normally, giving back-to-back neurons at one chunk per LATENCY+1 cycles.
- dp_value is ignored outside the capture edge.
- No overflow possible in acc for CHUNKS <= 8. Larger CHUNKS requires increasing ACC_SIZE.

Test Plan:
- Bench parameters: VAL_SIZE=26, CHUNKS=2, NEURONS=3, LATENCY=4.
- Basic: start at edge 0; dp_value=100 at edge 4. Start at edge 5; dp_value=50 at edge 9; bias=-20 -> neuron_valid one cycle after edge 10, neuron_value=130, neuron_index=0, busy low after.
- ReLU/saturation:
  - Chunks -300 and 100 with bias 0 -> neuron_value=0.
  - Chunks 0x1FFFFFF and 0x1FFFFFF with bias 1 -> neuron_value=0x1FFFFFF.
- Argmax with tie: neuron activations 40, 90, 90 -> class_valid with the third neuron_valid, class_index=1, class_value=90; neuron_cnt wraps to 0; next neuron reports neuron_index=0.
- Busy collision: start again 2 cycles after an accepted start -> ignored, err=1 sticky. Capture still occurs at edge 4 with the correct value.
- Dp_value timing: dp_value=7 everywhere except 1000 exactly at the capture edge -> accumulated chunk equals 1000.
- Reset mid-operation: GlobalReset pulsed while in WAIT of neuron 1 -> all outputs 0 asynchronously. A following full 3-neuron run gives class results independent of the aborted data.
